lbm_step_scheduler: RTL
=======================

Name: lbm_step_scheduler

Overview:
Top-level sequencer for one lattice-Boltzmann run over the 2500-pixel lattice.
- Requests the initial lattice load from DDR through the AXI-Stream pixel unpacker and counts its BRAM write strobes.
- Fires collide/stream timesteps on the compute engine and triggers DDR writeback at snapshot points and at end of run.
- Sits between the PS-facing control registers and the load, compute and writeback datapaths.

Parameters:
DEPTH, 2500, pixels per lattice; number of load write strobes expected per load.
ADDRESS_WIDTH, 12, width of pixel counter and loader address.
STEP_WIDTH, 16, width of timestep counters.
SNAP_INTERVAL, 0, timesteps between intermediate writebacks; 0 = writeback only at end.
TIMEOUT_CYCLES, 65535, watchdog limit per phase (only used with optional feature).

Ports:
m00_axis_aclk  in  1  sole clock
m00_axis_areset  in  1  synchronous active-high reset
start  in  1  run request, sampled in IDLE only
abort  in  1  cancel run, any state
num_steps  in  STEP_WIDTH  timesteps to run, latched on accepted start
load_req  out  1  one-cycle pulse: DMA begins MM2S of lattice
pix_wen  in  1  loader BRAM write strobe, one per pixel
pix_addr  in  ADDRESS_WIDTH  loader write address, used for checking
compute_start  out  1  one-cycle pulse: run one timestep
compute_done  in  1  one-cycle pulse: timestep finished
wb_req  out  1  one-cycle pulse: start S2MM writeback of lattice
wb_done  in  1  one-cycle pulse: writeback complete
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on run completion
err  out  1  sticky; set on load mismatch or timeout, cleared on accepted start
step_count  out  STEP_WIDTH  completed timesteps in current run

Behaviour:
- Reset (synchronous; wins over all other inputs): state=IDLE. load_req, compute_start, wb_req, busy, done and err are 0. step_count=0. Pixel counter=0.
- States: IDLE, LOAD_REQ, LOAD, COMPUTE_REQ, COMPUTE, WB_REQ, WB, FINISH.
- IDLE: start=1 latches num_steps, clears err and step_count.
  - If num_steps=0: go to FINISH; no load is issued.
  - Otherwise: go to LOAD_REQ.
- LOAD_REQ: load_req=1 for this cycle only; clear pixel counter; go to LOAD.
- LOAD: each pix_wen increments the pixel counter.
  - If pix_addr differs from the counter value on a pix_wen, set err; the load still completes.
  - On the cycle the counter reaches DEPTH: go to COMPUTE_REQ.
- COMPUTE_REQ: compute_start=1 for one cycle; go to COMPUTE.
- COMPUTE: on compute_done, step_count increments.
  - If step_count+1 == latched num_steps: go to WB_REQ (final writeback).
  - Else if SNAP_INTERVAL != 0 and (step_count+1) mod SNAP_INTERVAL == 0: go to WB_REQ (snapshot).
  - Otherwise: go to COMPUTE_REQ.
- WB_REQ: wb_req=1 for one cycle; go to WB.
- WB: on wb_done, go to FINISH if the run is complete, else to COMPUTE_REQ.
- FINISH: done=1 for one cycle; go to IDLE.
- Latency: start to load_req is exactly 1 cycle. compute_done to the next compute_start is exactly 1 cycle when no writeback is due.
- Completion pulses (compute_done, wb_done) arriving outside their waiting state are ignored.
- pix_wen outside LOAD is ignored.
- abort: next state is IDLE from any state; no done pulse; step_count holds its value. abort takes priority over start in the same cycle.
- start while busy is ignored.
- Pulse outputs are registered and never high in two consecutive cycles.
- Counters saturate; no wrap beyond num_steps.

Optional Feature:
LBM_SCHED_TIMEOUT_EN
- Defined: a cycle counter resets on each state entry.
  - In LOAD, COMPUTE or WB, reaching TIMEOUT_CYCLES sets err and forces IDLE, with no done pulse.
- Undefined: no watchdog logic; the waiting states wait indefinitely.

Decomposition:
- Shared package lbm_pkg: state encoding constants; DEPTH=2500 and ADDRESS_WIDTH=12 lattice constants; STEP_WIDTH.
- One natural sub-module: lbm_phase_watchdog, the per-phase timeout counter, instantiated only under the macro.

Test Plan:
- num_steps=3, SNAP_INTERVAL=0, 2500 pix_wen with matching addresses, compute_done 10 cycles after each compute_start -> exactly 3 compute_start pulses, 1 wb_req, done once, step_count=3, err=0.
- num_steps=4, SNAP_INTERVAL=2 -> wb_req after steps 2 and 4 only, done after the second wb_done.
- num_steps=0 -> no load_req, compute_start or wb_req; done pulses 2 cycles after start.
- pix_addr skips value 100 during load -> err=1 sticky, run still completes, err cleared by the next start.
- abort asserted mid-COMPUTE at step 2 -> IDLE next cycle, busy=0, no done, step_count=2; a late compute_done is ignored.
- With LBM_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=50, compute_done withheld -> err=1 and IDLE 50 cycles after entering COMPUTE.

Source files
------------

// File: rtl/lbm_pkg.sv
// Shared constants and state encoding for the lattice-Boltzmann run sequencer.
// Optional watchdog build switch used by the top: LBM_SCHED_TIMEOUT_EN.
package lbm_pkg;

    localparam int LBM_DEPTH          = 2500;
    localparam int LBM_ADDRESS_WIDTH  = 12;
    localparam int LBM_STEP_WIDTH     = 16;
    localparam int LBM_SNAP_INTERVAL  = 0;
    localparam int LBM_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD_REQ    = 3'd1,
        ST_LOAD        = 3'd2,
        ST_COMPUTE_REQ = 3'd3,
        ST_COMPUTE     = 3'd4,
        ST_WB_REQ      = 3'd5,
        ST_WB          = 3'd6,
        ST_FINISH      = 3'd7
    } lbm_state_e;

    // States that wait on an external datapath and can therefore stall.
    function automatic logic is_wait_state(input lbm_state_e s);
        logic w;
        case (s)
            ST_LOAD, ST_COMPUTE, ST_WB: w = 1'b1;
            default:                    w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lbm_phase_watchdog.sv
// Per-phase cycle counter: restarts on every state change and flags expiry
// after TIMEOUT_CYCLES cycles in an armed (waiting) state.
module lbm_phase_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    input  logic arm_i,
    output logic expire_o
);

    localparam int              CW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   ONE   = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: zero on phase entry, otherwise count up and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count value LIMIT is the TIMEOUT_CYCLES-th cycle spent in the phase.
    assign expire_o = arm_i && (cnt_q == LIMIT);

endmodule

// File: rtl/lbm_step_scheduler.sv
// Run sequencer: lattice load, collide/stream timesteps, snapshot and final writeback.
// Define LBM_SCHED_TIMEOUT_EN to add the per-phase watchdog (lbm_phase_watchdog).
module lbm_step_scheduler
    import lbm_pkg::*;
#(
    parameter int DEPTH          = LBM_DEPTH,
    parameter int ADDRESS_WIDTH  = LBM_ADDRESS_WIDTH,
    parameter int STEP_WIDTH     = LBM_STEP_WIDTH,
    parameter int SNAP_INTERVAL  = LBM_SNAP_INTERVAL,
    parameter int TIMEOUT_CYCLES = LBM_TIMEOUT_CYCLES
) (
    input  logic                     m00_axis_aclk,
    input  logic                     m00_axis_areset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [STEP_WIDTH-1:0]    num_steps,
    output logic                     load_req,
    input  logic                     pix_wen,
    input  logic [ADDRESS_WIDTH-1:0] pix_addr,
    output logic                     compute_start,
    input  logic                     compute_done,
    output logic                     wb_req,
    input  logic                     wb_done,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [STEP_WIDTH-1:0]    step_count
);

    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_LAST = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] PIX_ONE    = ADDRESS_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0]    STEP_ONE   = STEP_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0]    STEP_MAX   = '1;
    localparam logic                     SNAP_EN    = (SNAP_INTERVAL > 0);
    localparam logic [STEP_WIDTH-1:0]    SNAP_LAST  =
        STEP_WIDTH'((SNAP_INTERVAL > 0) ? (SNAP_INTERVAL - 1) : 0);

    lbm_state_e               state_q, state_d;
    logic [STEP_WIDTH-1:0]    num_q, num_d;
    logic [ADDRESS_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [STEP_WIDTH-1:0]    step_q, step_d;
    logic [STEP_WIDTH-1:0]    snap_q, snap_d;
    logic                     err_q, err_d;
    logic                     load_req_q, compute_start_q, wb_req_q, busy_q, done_q;
    logic [STEP_WIDTH-1:0]    step_inc_s, snap_next_s;
    logic                     snap_hit_s;
    logic                     timeout_s;

    assign step_inc_s  = (step_q == STEP_MAX) ? step_q : step_q + STEP_ONE;
    // snap_q tracks completed steps modulo SNAP_INTERVAL, avoiding a divider.
    assign snap_next_s = (snap_q == SNAP_LAST) ? '0 : snap_q + STEP_ONE;
    assign snap_hit_s  = SNAP_EN && (snap_q == SNAP_LAST);

`ifdef LBM_SCHED_TIMEOUT_EN
    lbm_phase_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (m00_axis_aclk),
        .rst_i     (m00_axis_areset),
        .restart_i (state_d != state_q),
        .arm_i     (is_wait_state(state_q)),
        .expire_o  (timeout_s)
    );
`else
    assign timeout_s = (TIMEOUT_CYCLES < 0) ? 1'b1 : 1'b0;
`endif

    // Next-state and datapath-register update.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        pix_cnt_d = pix_cnt_q;
        step_d    = step_q;
        snap_d    = snap_q;
        err_d     = err_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (timeout_s) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        num_d  = num_steps;
                        err_d  = 1'b0;
                        step_d = '0;
                        snap_d = '0;
                        if (num_steps == '0) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d = ST_LOAD_REQ;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD_REQ: begin
                    pix_cnt_d = '0;
                    state_d   = ST_LOAD;
                end
                ST_LOAD: begin
                    if (pix_wen) begin
                        pix_cnt_d = pix_cnt_q + PIX_ONE;
                        if (pix_addr != pix_cnt_q) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                        if (pix_cnt_q == DEPTH_LAST) begin
                            state_d = ST_COMPUTE_REQ;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_COMPUTE_REQ: state_d = ST_COMPUTE;
                ST_COMPUTE: begin
                    if (compute_done) begin
                        step_d = step_inc_s;
                        snap_d = snap_next_s;
                        if (step_inc_s == num_q) begin
                            state_d = ST_WB_REQ;
                        end else if (snap_hit_s) begin
                            state_d = ST_WB_REQ;
                        end else begin
                            state_d = ST_COMPUTE_REQ;
                        end
                    end else begin
                        state_d = ST_COMPUTE;
                    end
                end
                ST_WB_REQ: state_d = ST_WB;
                ST_WB: begin
                    if (wb_done) begin
                        state_d = (step_q == num_q) ? ST_FINISH : ST_COMPUTE_REQ;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs; request pulses coincide with their
    // one-cycle states, while done follows FINISH so it lines up with busy falling.
    always_ff @(posedge m00_axis_aclk) begin
        if (m00_axis_areset) begin
            state_q         <= ST_IDLE;
            num_q           <= '0;
            pix_cnt_q       <= '0;
            step_q          <= '0;
            snap_q          <= '0;
            err_q           <= 1'b0;
            load_req_q      <= 1'b0;
            compute_start_q <= 1'b0;
            wb_req_q        <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            num_q           <= num_d;
            pix_cnt_q       <= pix_cnt_d;
            step_q          <= step_d;
            snap_q          <= snap_d;
            err_q           <= err_d;
            load_req_q      <= (state_d == ST_LOAD_REQ);
            compute_start_q <= (state_d == ST_COMPUTE_REQ);
            wb_req_q        <= (state_d == ST_WB_REQ);
            busy_q          <= (state_d != ST_IDLE);
            done_q          <= (state_q == ST_FINISH) && !abort;
        end
    end

    assign load_req      = load_req_q;
    assign compute_start = compute_start_q;
    assign wb_req        = wb_req_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign step_count    = step_q;

endmodule
